led_bound_monitor: RTL

- Receive-side decoder for the 16-lamp bound flasher LED bus.
- Samples the thermometer-coded LED vector every clock and decodes it into:
  - a lamp level,
  - a direction,
  - turnaround (peak/trough) events,
  - a completed-cycle count.
- Flags illegal patterns and illegal steps.
- Sits beside the flasher in the chip-level wrapper as an on-chip self-check and status source.

---
 rtl/led_bound_monitor.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/led_bound_monitor.sv
// Receive-side decoder for the thermometer-coded bound flasher LED bus.
// Tracks level, direction, turnarounds and completed cycles; flags bad patterns.
module led_bound_monitor #(
    parameter int N_LED = 16,
    parameter int LVL_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_LED-1:0] led,
    input  logic             clr,
    output logic [LVL_W-1:0] level,
    output logic [1:0]       dir,
    output logic             ext_valid,
    output logic             ext_is_peak,
    output logic [LVL_W-1:0] ext_level,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RISING  = 2'b01,
        FALLING = 2'b10
    } state_t;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;
    localparam logic [1:0] E_NONE   = 2'b00;
    localparam logic [1:0] E_THERM  = 2'b01;
    localparam logic [1:0] E_STEP   = 2'b10;

    localparam logic [N_LED:0] ONE_M = {{N_LED{1'b0}}, 1'b1};
    localparam logic [LVL_W:0] ONE_L = {{LVL_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       dir_q, dir_d;
    logic             ev_q, ev_d;
    logic             pk_q, pk_d;
    logic [LVL_W-1:0] el_q, el_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic [LVL_W-1:0] d;
    logic [N_LED:0]   mask;
    logic             thermo;
    logic             up;
    logic             dn;
    logic             big;
    logic             inc;
    logic             e_nt;
    logic             e_step;
    logic             err_b;
    logic [1:0]       code_b;

    always_comb begin
        d = '0;
        for (int i = 0; i < N_LED; i++) begin
            d = d + LVL_W'(led[i]);
        end
        mask   = (ONE_M << d) - ONE_M;
        thermo = (led == mask[N_LED-1:0]);
        up     = d > level_q;
        dn     = d < level_q;
        big    = ({1'b0, d} > ({1'b0, level_q} + ONE_L)) ||
                 ({1'b0, level_q} > ({1'b0, d} + ONE_L));
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        dir_d   = dir_q;
        ev_d    = 1'b0;
        pk_d    = pk_q;
        el_d    = el_q;
        inc     = 1'b0;
        e_nt    = 1'b0;
        e_step  = 1'b0;

        if (!thermo) begin
            e_nt = 1'b1;
        end else if (big) begin
            level_d = d;
            dir_d   = DIR_HOLD;
            e_step  = 1'b1;
            if (d == '0) begin
                state_d = IDLE;
            end
        end else begin
            level_d = d;
            dir_d   = up ? DIR_UP : (dn ? DIR_DN : DIR_HOLD);
            unique case (state_q)
                IDLE: begin
                    if (up) state_d = RISING;
                end
                RISING: begin
                    if (dn) begin
                        state_d = FALLING;
                        ev_d    = 1'b1;
                        pk_d    = 1'b1;
                        el_d    = level_q;
                        if (d == '0) begin
                            state_d = IDLE;
                            inc     = 1'b1;
                        end
                    end
                end
                FALLING: begin
                    if (up) begin
                        state_d = RISING;
                        ev_d    = 1'b1;
                        pk_d    = 1'b0;
                        el_d    = level_q;
                    end else if (dn && d == '0) begin
                        state_d = IDLE;
                        inc     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // clr applies first so an error detected in the same cycle is kept
    always_comb begin
        err_b  = clr ? 1'b0 : err_q;
        code_b = clr ? E_NONE : code_q;
        err_d  = err_b | e_nt | e_step;
        code_d = code_b;
        if (!err_b) begin
            if (e_nt) begin
                code_d = E_THERM;
            end else if (e_step) begin
                code_d = E_STEP;
            end
        end
        if (clr) begin
            cnt_d = '0;
        end else if (inc && cnt_q != '1) begin
            cnt_d = cnt_q + ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= '0;
            dir_q   <= DIR_HOLD;
            ev_q    <= 1'b0;
            pk_q    <= 1'b0;
            el_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= E_NONE;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            dir_q   <= dir_d;
            ev_q    <= ev_d;
            pk_q    <= pk_d;
            el_q    <= el_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign level       = level_q;
    assign dir         = dir_q;
    assign ext_valid   = ev_q;
    assign ext_is_peak = pk_q;
    assign ext_level   = el_q;
    assign cycle_cnt   = cnt_q;
    assign err         = err_q;
    assign err_code    = code_q;

endmodule
